tmds_decoder: RTL and testbench

Receive-side counterpart of the TMDS encoder, one instance per TMDS channel in the DVI sink path. Takes raw 10-bit words from the channel deserializer, finds word alignment by requesting bit slips until control tokens appear during blanking, and decodes each aligned word into `DE`, `C0`, `C1` and the 8-bit data byte. It also flags data words that violate the transition-minimisation rule. Output feeds the channel-deskew and sync-recovery logic.

---
 rtl/tmds_pkg.sv | 17 +
 rtl/tmds_align_fsm.sv | 116 +++++++++++
 rtl/tmds_decoder.sv | 114 +++++++++++
 tb/tb_tmds_decoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes and the word-alignment state type.
package tmds_pkg;

  // 10-bit control tokens sent during blanking, named by their {C1,C0} value.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_t;

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-alignment FSM: requests bit slips until a run of control tokens is
// seen, then holds lock until control tokens stop arriving for too long.
module tmds_align_fsm #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic is_ctrl,
  output logic bitslip_o,
  output logic locked_o
);
  import tmds_pkg::*;

  // One shared timer serves search, settle and lock supervision, so it is
  // sized for the largest terminal value of the three.
  localparam int TMR_MAX_A = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMR_MAX   = (TMR_MAX_A > SLIP_SETTLE) ? TMR_MAX_A : SLIP_SETTLE;
  localparam int RUN_W     = $clog2(CTRL_RUN) + 1;
  localparam int TMR_W     = $clog2(TMR_MAX) + 1;

  localparam logic [RUN_W-1:0] RUN_LOCK       = RUN_W'(CTRL_RUN);
  localparam logic [TMR_W-1:0] TMR_SEARCH_END = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_SETTLE_END = TMR_W'(SLIP_SETTLE - 1);
  localparam logic [TMR_W-1:0] TMR_LOCK_END   = TMR_W'(LOCK_TIMEOUT - 1);

  align_state_t     r_state;
  align_state_t     w_state_next;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_next;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_next;
  logic             r_bitslip;
  logic             r_locked;

  // Next-state and counter logic; every exit path clears the counters so
  // they start each state from zero and can never wrap.
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    w_tmr_next   = r_tmr;
    case (r_state)
      ST_SEARCH: begin
        if (!is_ctrl) begin
          w_run_next = '0;
        end else if (r_run != RUN_LOCK) begin
          w_run_next = r_run + RUN_W'(1);
        end
        // Lock takes priority over a simultaneous search timeout.
        if (w_run_next == RUN_LOCK) begin
          w_state_next = ST_LOCKED;
          w_run_next   = '0;
          w_tmr_next   = '0;
        end else if (r_tmr == TMR_SEARCH_END) begin
          w_state_next = ST_SLIP;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next = r_tmr + TMR_W'(1);
        end
      end
      ST_SLIP: begin
        w_state_next = ST_SETTLE;
        w_run_next   = '0;
        w_tmr_next   = '0;
      end
      ST_SETTLE: begin
        if (r_tmr == TMR_SETTLE_END) begin
          w_state_next = ST_SEARCH;
          w_run_next   = '0;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next = r_tmr + TMR_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_ctrl) begin
          w_tmr_next = '0;
        end else if (r_tmr == TMR_LOCK_END) begin
          w_state_next = ST_SEARCH;
          w_run_next   = '0;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_state_next = ST_SEARCH;
        w_run_next   = '0;
        w_tmr_next   = '0;
      end
    endcase
  end

  // State, counters and the registered Moore outputs that mirror the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_SEARCH;
      r_run     <= '0;
      r_tmr     <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run     <= w_run_next;
      r_tmr     <= w_tmr_next;
      r_bitslip <= (w_state_next == ST_SLIP);
      r_locked  <= (w_state_next == ST_LOCKED);
    end
  end

  assign bitslip_o = r_bitslip;
  assign locked_o  = r_locked;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: registers the raw word, decodes control tokens and
// data bytes, flags transition-minimisation errors and drives word alignment.
module tmds_decoder #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_SETTLE    = 4,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] data_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic       c0_o,
  output logic       c1_o,
  output logic [7:0] d_o,
  output logic       err_o
);
  import tmds_pkg::*;

  logic [9:0] r_w;
  logic       w_is_ctrl;
  logic [1:0] w_ctrl_bits;
  logic [7:0] w_q;
  logic [7:0] w_d;
  logic [3:0] w_n1;
  logic       w_exp_b8;
  logic       w_err;
  logic       r_de;
  logic       r_c0;
  logic       r_c1;
  logic [7:0] r_d;
  logic       r_err;

  // Input stage: every decode and alignment decision works from this copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_w <= '0;
    end else begin
      r_w <= data_i;
    end
  end

  // Control-token recognition and its {C1,C0} value.
  always_comb begin
    w_is_ctrl   = 1'b1;
    w_ctrl_bits = 2'b00;
    case (r_w)
      CTRL_TOKEN_00: w_ctrl_bits = 2'b00;
      CTRL_TOKEN_01: w_ctrl_bits = 2'b01;
      CTRL_TOKEN_10: w_ctrl_bits = 2'b10;
      CTRL_TOKEN_11: w_ctrl_bits = 2'b11;
      default:       w_is_ctrl   = 1'b0;
    endcase
  end

  // Undo the optional DC-balance inversion, then the XOR/XNOR chain.
  assign w_q    = r_w[9] ? ~r_w[7:0] : r_w[7:0];
  assign w_d[0] = w_q[0];

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_dechain
      assign w_d[gi] = r_w[8] ? (w_q[gi] ^ w_q[gi-1]) : ~(w_q[gi] ^ w_q[gi-1]);
    end
  endgenerate

  // An encoder would have chosen XNOR (bit 8 = 0) for bytes with many ones;
  // a received bit 8 disagreeing with that choice marks a corrupt word.
  assign w_n1     = 4'($countones(w_d));
  assign w_exp_b8 = !((w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_d[0]));
  assign w_err    = (r_w[8] != w_exp_b8);

  // Output stage: control fields and data byte each hold while the other is active.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_de  <= 1'b0;
      r_c0  <= 1'b0;
      r_c1  <= 1'b0;
      r_d   <= 8'h00;
      r_err <= 1'b0;
    end else if (w_is_ctrl) begin
      r_de  <= 1'b0;
      r_c0  <= w_ctrl_bits[0];
      r_c1  <= w_ctrl_bits[1];
      r_err <= 1'b0;
    end else begin
      r_de  <= 1'b1;
      r_d   <= w_d;
      r_err <= w_err;
    end
  end

  assign de_o  = r_de;
  assign c0_o  = r_c0;
  assign c1_o  = r_c1;
  assign d_o   = r_d;
  assign err_o = r_err;

  tmds_align_fsm #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_SETTLE    (SLIP_SETTLE),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) u_align (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .is_ctrl   (w_is_ctrl),
    .bitslip_o (bitslip_o),
    .locked_o  (locked_o)
  );

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed alignment sequences plus randomized words
// checked against a rule-level decode model and an independent TMDS encoder.
module tb_tmds_decoder;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [9:0] data_i;
  logic       bitslip_o;
  logic       locked_o;
  logic       de_o;
  logic       c0_o;
  logic       c1_o;
  logic [7:0] d_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int slip_cycles[$];
  int lock_hi_cnt = 0;

  // Expected output state and the word whose decode is due next.
  logic       m_de, m_c1, m_c0, m_err;
  logic [7:0] m_d;
  logic [9:0] prev_word;
  logic       prev_bv;
  logic [7:0] prev_b;

  tmds_decoder dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .bitslip_o (bitslip_o),
    .locked_o  (locked_o),
    .de_o      (de_o),
    .c0_o      (c0_o),
    .c1_o      (c1_o),
    .d_o       (d_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_is_ctrl(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] ref_ctrl(input logic [9:0] w);
    if (w == 10'h0AB) return 2'b01;
    if (w == 10'h154) return 2'b10;
    if (w == 10'h2AB) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [7:0] ref_data(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic ref_err(input logic [9:0] w);
    logic [7:0] d;
    int n;
    logic exp8;
    d = ref_data(w);
    n = $countones(d);
    exp8 = ((n > 4) || (n == 4 && d[0] == 1'b0)) ? 1'b0 : 1'b1;
    return w[8] != exp8;
  endfunction

  // Transmit-side TMDS encoding of a byte (minimisation stage plus optional inversion).
  function automatic logic [9:0] encode(input logic [7:0] b, input logic inv);
    logic [7:0] qm;
    logic use_xnor;
    int n;
    n = $countones(b);
    use_xnor = (n > 4) || (n == 4 && b[0] == 1'b0);
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? !(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    return {inv, !use_xnor, inv ? ~qm : qm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: present a word, then check the outputs produced from the previous word.
  task automatic tick(input logic [9:0] word, input logic bv, input logic [7:0] b);
    data_i = word;
    @(posedge clk_i);
    #1;
    cyc++;
    if (bitslip_o === 1'b1) slip_cycles.push_back(cyc);
    if (locked_o === 1'b1) lock_hi_cnt++;
    if (ref_is_ctrl(prev_word)) begin
      m_de = 1'b0;
      {m_c1, m_c0} = ref_ctrl(prev_word);
      m_err = 1'b0;
    end else begin
      m_de  = 1'b1;
      m_d   = ref_data(prev_word);
      m_err = ref_err(prev_word);
    end
    check("decode", {20'h0, de_o, c1_o, c0_o, d_o, err_o}, {20'h0, m_de, m_c1, m_c0, m_d, m_err});
    if (prev_bv) check("enc_byte", {23'h0, d_o, err_o}, {23'h0, prev_b, 1'b0});
    prev_word = word;
    prev_bv   = bv;
    prev_b    = b;
  endtask

  task automatic tick_w(input logic [9:0] word);
    tick(word, 1'b0, 8'h00);
  endtask

  task automatic tick_data();
    logic [7:0] b;
    logic [9:0] w;
    b = 8'($urandom_range(0, 255));
    w = encode(b, 1'($urandom_range(0, 1)));
    if (ref_is_ctrl(w)) tick_w(10'h3FF);
    else tick(w, 1'b1, b);
  endtask

  task automatic model_reset();
    m_de = 0; m_c1 = 0; m_c0 = 0; m_err = 0; m_d = 8'h00;
    prev_word = 10'h000; prev_bv = 1'b0; prev_b = 8'h00;
    cyc = 0; lock_hi_cnt = 0;
    slip_cycles.delete();
  endtask

  // Assert reset between clock edges and check that it bites without a clock.
  task automatic assert_reset(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    check(tag, {25'h0, bitslip_o, locked_o, de_o, c0_o, c1_o, d_o, err_o}, 32'h0);
    model_reset();
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check("rst_hold", {30'h0, bitslip_o, locked_o}, 32'h0);
    end
    data_i = 10'h000;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int base, fall;
    logic [9:0] toks [4];
    toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;

    // Power-on reset.
    rst_i  = 1'b1;
    data_i = 10'h000;
    model_reset();
    #3;
    check("rst_outs", {25'h0, bitslip_o, locked_o, de_o, c0_o, c1_o, d_o, err_o}, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Eight control tokens: lock after the edge following the 8th in w.
    for (int i = 0; i < 8; i++) tick_w(10'h354);
    check("lock_early", {31'h0, locked_o}, 32'h0);
    tick_w(10'h100);
    check("lock_rise", {31'h0, locked_o}, 32'h1);
    tick_w(10'h200);
    check("d_100", {23'h0, de_o, d_o}, {23'h0, 1'b1, 8'h00});
    tick_w(10'h0AB);
    check("d_200", {23'h0, de_o, d_o}, {23'h0, 1'b1, 8'hFF});
    tick_w(10'h2AB);
    check("c_0AB", {29'h0, de_o, c1_o, c0_o}, {29'h0, 3'b001});
    tick_w(10'h055);
    check("c_2AB", {29'h0, de_o, c1_o, c0_o}, {29'h0, 3'b011});
    tick_w(10'h354);
    check("err_055", {23'h0, d_o, err_o}, {23'h0, 8'h01, 1'b1});
    check("no_slip_lock", slip_cycles.size(), 0);

    // Randomized traffic while locked.
    lock_hi_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       tick_w(toks[$urandom_range(0, 3)]);
        1:       tick_w(10'($urandom_range(0, 1023)));
        default: tick_data();
      endcase
    end
    check("lock_held", lock_hi_cnt, 400);

    // Lock timeout: last control token, then data only.
    slip_cycles.delete();
    tick_w(10'h154);
    base = cyc;
    fall = -1;
    for (int i = 0; i < 4096 + 1024 + 3; i++) begin
      tick_data();
      if (fall < 0 && locked_o === 1'b0) fall = cyc;
    end
    check("lock_fall", fall, base + 4097);
    check("slip_cnt_after_unlock", slip_cycles.size(), 1);
    if (slip_cycles.size() > 0) check("slip_after_unlock", slip_cycles[0], base + 4097 + 1024);

    // Constant data from reset: periodic slips, never locks.
    assert_reset("rst_locked");
    for (int i = 0; i < 3100; i++) tick_w(10'h3FF);
    check("slip_period_cnt", slip_cycles.size(), 3);
    if (slip_cycles.size() == 3) begin
      check("slip_first", slip_cycles[0], 1024);
      check("slip_second", slip_cycles[1], 1024 + 1029);
      check("slip_third", slip_cycles[2], 1024 + 2 * 1029);
    end
    check("never_locked", lock_hi_cnt, 0);

    // Reset while the slip request is high.
    assert_reset("rst_pre");
    for (int i = 0; i < 1024; i++) tick_w(10'h3FF);
    check("in_slip", {31'h0, bitslip_o}, 32'h1);
    assert_reset("rst_slip");
    for (int i = 0; i < 8; i++) tick_w(10'h0AB);
    tick_w(10'h3FF);
    check("relock", {31'h0, locked_o}, 32'h1);
    check("no_slip_relock", slip_cycles.size(), 0);

    // Reset while locked, then confirm a fresh search timer.
    assert_reset("rst_lock2");
    for (int i = 0; i < 1026; i++) tick_w(10'h3FF);
    check("restart_slip_cnt", slip_cycles.size(), 1);
    if (slip_cycles.size() > 0) check("restart_slip", slip_cycles[0], 1024);
    check("restart_unlocked", lock_hi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
